// File: rtl/prog_clk_gen_pkg.sv
// Shared constants and half-period helpers for the programmable clock generator.
// Helpers work on 32-bit values; callers cast to and from the channel counter width.
package prog_clk_gen_pkg;

    localparam int CW_DEFAULT           = 25;
    localparam int DEFAULT_HALF_DEFAULT = 25000000;

    // A programmed half-period of zero behaves as one (divide-by-2).
    function automatic logic [31:0] eff_half(input logic [31:0] h);
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

    // Counter start value so the first toggle lands on the second enabled edge.
    function automatic logic [31:0] preset_of(input logic [31:0] h);
        logic [31:0] e;
        e = eff_half(h);
        return (e >= 32'd2) ? (e - 32'd2) : 32'd0;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/shadow half-period registers,
// registered divided clock with rise/fall tick pulses.
module clk_div_chan
    import prog_clk_gen_pkg::*;
#(
    parameter int CW           = CW_DEFAULT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [CW-1:0] half_period,
    input  logic          load,
    input  logic          sync_restart,
    output logic          sclk,
    output logic          tick_rise,
    output logic          tick_fall,
    output logic          pending
);

    localparam logic [CW-1:0] RST_HALF = CW'(DEFAULT_HALF);
    localparam logic [CW-1:0] RST_CNT  = CW'(DEFAULT_HALF - 2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          sclk_q, sclk_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] h_eff;

    always_comb begin
        h_d      = h_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        sclk_d   = sclk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        h_eff    = CW'(eff_half(32'(h_q)));

        if (sync_restart && enable) begin
            // A load presented with the restart bypasses the shadow and never pends.
            if (load) begin
                h_d      = half_period;
                shadow_d = half_period;
            end else if (pend_q) begin
                h_d = shadow_q;
            end
            pend_d = 1'b0;
            cnt_d  = CW'(preset_of(32'(h_d)));
            sclk_d = 1'b0;
        end else begin
            if (!enable) begin
                if (pend_q) begin
                    h_d    = shadow_q;
                    pend_d = 1'b0;
                end
                cnt_d  = CW'(preset_of(32'(h_d)));
                sclk_d = 1'b0;
            end else if (cnt_q == (h_eff - ONE)) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
                rise_d = ~sclk_q;
                fall_d = sclk_q;
                if (pend_q) begin
                    h_d    = shadow_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end

            // A new capture always wins over a same-cycle apply of the old shadow.
            if (load) begin
                shadow_d = half_period;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q      <= RST_HALF;
            shadow_q <= RST_HALF;
            cnt_q    <= RST_CNT;
            pend_q   <= 1'b0;
            sclk_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            h_q      <= h_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            sclk_q   <= sclk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sclk      = sclk_q;
    assign tick_rise = rise_q;
    assign tick_fall = fall_q;
    assign pending   = pend_q;

endmodule

// File: rtl/prog_clk_gen.sv
// Programmable multi-channel clock generator: slices the flattened half-period
// bus and fans the load/restart strobes out to NCH independent divider channels.
module prog_clk_gen
    import prog_clk_gen_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int CW           = CW_DEFAULT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    enable,
    input  logic [NCH*CW-1:0] half_period,
    input  logic              load,
    input  logic              sync_restart,
    output logic [NCH-1:0]    sclk,
    output logic [NCH-1:0]    tick_rise,
    output logic [NCH-1:0]    tick_fall,
    output logic [NCH-1:0]    pending
);

    if (CW < 2 || CW > 32 || DEFAULT_HALF < 2 ||
        longint'(DEFAULT_HALF) > ((longint'(1) << CW) - longint'(1))) begin : g_bad_param
        $error("prog_clk_gen: DEFAULT_HALF out of range for CW");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .CW           (CW),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .enable       (enable[i]),
            .half_period  (half_period[i*CW +: CW]),
            .load         (load),
            .sync_restart (sync_restart),
            .sclk         (sclk[i]),
            .tick_rise    (tick_rise[i]),
            .tick_fall    (tick_fall[i]),
            .pending      (pending[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_gen.sv
// Scoreboard bench for prog_clk_gen (NCH=2, CW=8, DEFAULT_HALF=4): stimulus queues
// hand-computed tick events per channel, a negedge monitor pops and compares them.
module tb_prog_clk_gen;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int DH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    enable = 2'b11;
    logic [NCH*CW-1:0] half_period = '0;
    logic              load = 1'b0;
    logic              sync_restart = 1'b0;
    logic [NCH-1:0]    sclk, tick_rise, tick_fall, pending;

    prog_clk_gen #(.NCH(NCH), .CW(CW), .DEFAULT_HALF(DH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .half_period  (half_period),
        .load         (load),
        .sync_restart (sync_restart),
        .sclk         (sclk),
        .tick_rise    (tick_rise),
        .tick_fall    (tick_fall),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit rise;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int c, input bit r);
        ev_t e;
        e.cyc  = c;
        e.rise = r;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic push_per(input int ch, input int first, input int h, input int upto, input bit r0);
        bit r;
        r = r0;
        for (int t = first; t <= upto; t += h) begin
            push(ch, t, r);
            r = ~r;
        end
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [NCH-1:0] en);
        reset        = 1'b1;
        load         = 1'b0;
        sync_restart = 1'b0;
        half_period  = '0;
        enable       = en;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_ticks", 32'({tick_rise, tick_fall}), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        b     = cyc;
    endtask

    task automatic end_scn(input string name, input int upto);
        goto_cyc(upto);
        @(negedge clk);
        #1;
        check({name, "_ch0_events_left"}, 32'(q0.size()), 32'd0);
        check({name, "_ch1_events_left"}, 32'(q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    // Monitor: every tick must match the head of its channel's queue.
    ev_t e;
    bit  got;
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            while ((ch == 0 && q0.size() > 0 && q0[0].cyc < cyc) ||
                   (ch == 1 && q1.size() > 0 && q1[0].cyc < cyc)) begin
                if (ch == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missed_tick ch%0d: no tick seen, required rise=%0b at cycle %0d (now %0d)",
                         ch, e.rise, e.cyc, cyc);
            end
            if (tick_rise[ch] || tick_fall[ch]) begin
                got = 1'b0;
                if (ch == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); got = 1'b1;
                end else if (ch == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); got = 1'b1;
                end
                n_chk++;
                if (!got) begin
                    n_fail++;
                    $display("FAIL unexpected_tick ch%0d: rise=%0b fall=%0b at cycle %0d, required none",
                             ch, tick_rise[ch], tick_fall[ch], cyc);
                end else if (e.cyc != cyc || tick_rise[ch] != e.rise || tick_fall[ch] == e.rise ||
                             sclk[ch] != e.rise) begin
                    n_fail++;
                    $display("FAIL tick_match ch%0d: got rise=%0b fall=%0b sclk=%0b at cycle %0d, required rise=%0b at cycle %0d",
                             ch, tick_rise[ch], tick_fall[ch], sclk[ch], cyc, e.rise, e.cyc);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_async_sclk", 32'(sclk), 32'd0);
        check("reset_async_pending", 32'(pending), 32'd0);

        // Release from reset, default half-period 4.
        do_reset(2'b11);
        push_per(0, b + 2, 4, b + 20, 1'b1);
        push_per(1, b + 2, 4, b + 20, 1'b1);
        goto_cyc(b + 1); check("s1_sclk_e1", 32'(sclk), 32'd0);
        goto_cyc(b + 2); check("s1_sclk_e2", 32'(sclk), 32'd3);
        goto_cyc(b + 6); check("s1_sclk_e6", 32'(sclk), 32'd0);
        end_scn("s1", b + 20);

        // Shadow load during the high phase, applied at the wrap.
        do_reset(2'b11);
        push(0, b + 2, 1'b1); push(0, b + 6, 1'b0);
        push_per(0, b + 8, 2, b + 20, 1'b1);
        push_per(1, b + 2, 4, b + 20, 1'b1);
        goto_cyc(b + 2); check("s2_pend_before", 32'(pending), 32'd0);
        half_period = {8'd4, 8'd2}; load = 1'b1;
        goto_cyc(b + 3); load = 1'b0; check("s2_pend_c1", 32'(pending), 32'd3);
        goto_cyc(b + 4); check("s2_pend_c2", 32'(pending), 32'd3);
        goto_cyc(b + 5); check("s2_pend_c3", 32'(pending), 32'd3);
        goto_cyc(b + 6); check("s2_pend_clear", 32'(pending), 32'd0);
        end_scn("s2", b + 20);

        // ch1 half-period 0 via load then sync_restart: divide-by-2.
        do_reset(2'b11);
        half_period = {8'd0, 8'd4}; load = 1'b1;
        goto_cyc(b + 1); load = 1'b0; sync_restart = 1'b1;
        check("s3_pend_loaded", 32'(pending), 32'd3);
        goto_cyc(b + 2); sync_restart = 1'b0;
        check("s3_pend_restart", 32'(pending), 32'd0);
        check("s3_sclk_restart", 32'(sclk), 32'd0);
        push_per(0, b + 4, 4, b + 12, 1'b1);
        push_per(1, b + 3, 1, b + 12, 1'b1);
        end_scn("s3", b + 12);

        // Disable ch0 while high for 5 cycles, then re-enable.
        do_reset(2'b11);
        push(0, b + 2, 1'b1);
        push_per(0, b + 9, 4, b + 20, 1'b1);
        push_per(1, b + 2, 4, b + 20, 1'b1);
        goto_cyc(b + 2); enable = 2'b10;
        goto_cyc(b + 3); check("s4_sclk_disabled", 32'(sclk), 32'd2);
        goto_cyc(b + 7); enable = 2'b11;
        goto_cyc(b + 8); check("s4_sclk_reen_e1", 32'(sclk[0]), 32'd0);
        goto_cyc(b + 9); check("s4_sclk_reen_e2", 32'(sclk[0]), 32'd1);
        end_scn("s4", b + 20);

        // Misaligned ch0 H=4 / ch1 H=3 realigned by sync_restart.
        do_reset(2'b11);
        half_period = {8'd3, 8'd4}; load = 1'b1;
        push(0, b + 2, 1'b1); push(0, b + 6, 1'b0); push(0, b + 10, 1'b1);
        push_per(0, b + 14, 4, b + 24, 1'b1);
        push(1, b + 2, 1'b1); push(1, b + 5, 1'b0); push(1, b + 8, 1'b1); push(1, b + 11, 1'b0);
        push_per(1, b + 14, 3, b + 24, 1'b1);
        goto_cyc(b + 1); load = 1'b0;
        goto_cyc(b + 11); sync_restart = 1'b1;
        goto_cyc(b + 12); sync_restart = 1'b0;
        check("s5_sclk_restart", 32'(sclk), 32'd0);
        goto_cyc(b + 14); check("s5_sclk_aligned", 32'(sclk), 32'd3);
        end_scn("s5", b + 24);

        // load and sync_restart together take effect at once.
        do_reset(2'b11);
        push(0, b + 2, 1'b1); push_per(0, b + 6, 2, b + 12, 1'b1);
        push(1, b + 2, 1'b1); push_per(1, b + 5, 1, b + 12, 1'b1);
        goto_cyc(b + 3); half_period = {8'd1, 8'd2}; load = 1'b1; sync_restart = 1'b1;
        goto_cyc(b + 4); load = 1'b0; sync_restart = 1'b0;
        check("s6_pend_same_cycle", 32'(pending), 32'd0);
        goto_cyc(b + 5); check("s6_pend_after", 32'(pending), 32'd0);
        end_scn("s6", b + 12);

        // Disabled channels apply the shadow next cycle; repeated load overwrites.
        do_reset(2'b00);
        half_period = {8'd3, 8'd5}; load = 1'b1;
        goto_cyc(b + 1); load = 1'b0; check("s7_pend_disabled", 32'(pending), 32'd3);
        goto_cyc(b + 2); check("s7_pend_applied", 32'(pending), 32'd0);
        goto_cyc(b + 3); enable = 2'b01;
        push(0, b + 5, 1'b1); push(0, b + 10, 1'b0);
        push_per(0, b + 12, 2, b + 16, 1'b1);
        goto_cyc(b + 5); half_period = {8'd3, 8'd9}; load = 1'b1;
        goto_cyc(b + 6); half_period = {8'd3, 8'd2};
        goto_cyc(b + 7); load = 1'b0;
        goto_cyc(b + 8); check("s7_pend_overwrite", 32'(pending), 32'd1);
        goto_cyc(b + 9); check("s7_pend_hold", 32'(pending), 32'd1);
        goto_cyc(b + 10); check("s7_pend_wrap", 32'(pending), 32'd0);
        end_scn("s7", b + 16);

        // Asynchronous reset mid-high-phase with a load pending.
        do_reset(2'b11);
        push(0, b + 2, 1'b1);
        push(1, b + 2, 1'b1);
        goto_cyc(b + 2); half_period = {8'd4, 8'd2}; load = 1'b1;
        goto_cyc(b + 3); load = 1'b0; check("s8_pend_set", 32'(pending), 32'd3);
        goto_cyc(b + 4);
        #2 reset = 1'b1;
        #1;
        check("s8_async_sclk", 32'(sclk), 32'd0);
        check("s8_async_ticks", 32'({tick_rise, tick_fall}), 32'd0);
        check("s8_async_pending", 32'(pending), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        b = cyc;
        push_per(0, b + 2, 4, b + 14, 1'b1);
        push_per(1, b + 2, 4, b + 14, 1'b1);
        goto_cyc(b + 5); check("s8_h_restored", 32'(sclk), 32'd3);
        end_scn("s8", b + 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
